serial_sub4: RTL
================

SERIAL_SUB4 -- requirements
Module: serial_sub4

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have ports a__0..a__3, input, 1 bit each: minuend, a__0 is the LSB.
REQ-005 SHALL have ports b__0..b__3, input, 1 bit each: subtrahend, b__0 is the LSB.
REQ-006 SHALL have port in_valid, input, 1 bit: operands are present.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-008 SHALL have ports d__0..d__3, output, 1 bit each: difference (a-b) mod 16.
REQ-009 SHALL have port out_valid, output, 1 bit: the difference is present.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port bout, output, 1 bit: final borrow, present only with SUB_BORROW_OUT_EN.

Function
REQ-012 SHALL be a bit-serial LSB-first subtractor using one full-subtractor cell and one borrow flop.
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 SHALL assert in_ready only in IDLE; in_ready is 0 in SHIFT and DONE.
REQ-015 SHALL latch a and b when in_valid&in_ready is sampled high, then clear the borrow, clear bit counter cnt, and enter SHIFT.
REQ-016 SHALL, in SHIFT, compute d[cnt]=a[cnt]^b[cnt]^br and br'=(~a&b)|(~(a^b)&br) each cycle, then increment cnt.
REQ-017 SHALL go SHIFT->DONE on the edge that processes cnt==3, i.e. the 4th SHIFT cycle.
REQ-018 SHALL have latency of exactly 5 edges: acceptance at edge T, SHIFT at edges T+1..T+4, out_valid=1 after edge T+4.
REQ-019 SHALL, in DONE, hold out_valid=1 with d__* (and bout) stable until out_ready is sampled high.
REQ-020 SHALL, on out_valid&out_ready, return to IDLE with out_valid=0; in_ready becomes 1 the next cycle, so there is no same-cycle overlap.
REQ-021 SHALL ignore in_valid outside IDLE; operand ports may change freely after acceptance.
REQ-022 SHALL keep d__* at the last result in IDLE and SHIFT, updating in place during SHIFT; d__* is meaningful only while out_valid=1.
REQ-023 SHALL wrap modulo 16 (3-9 gives 10) and never saturate.
REQ-024 SHALL treat out_ready as don't-care outside DONE.

Reset
REQ-025 SHALL, on rst=1, immediately force IDLE, cnt=0, br=0, d__*=0, out_valid=0 and bout=0; in_ready=1 once rst is released.
REQ-026 SHALL discard any partial operation on a mid-SHIFT or DONE reset, with no out_valid pulse.

Configuration
REQ-027 SHALL, when SUB_BORROW_OUT_EN is defined, provide port bout, registered at the DONE transition, equal to the final borrow (1 if a<b unsigned).
REQ-028 SHALL, without SUB_BORROW_OUT_EN, omit port bout; all other behaviour is identical.

Structure
REQ-029 SHALL take from shared package sub_pkg: WIDTH=4, CNT_W=2, and the state enum (IDLE, SHIFT, DONE).
REQ-030 SHALL instantiate sub-module fs1bit (inputs a, b, bin; outputs d, bout; combinational) once.

Verification
REQ-031 SHALL check that a=9, b=3 accepted -> out_valid after 5 edges, d=6, bout=0.
REQ-032 SHALL check that a=3, b=9 -> d=10 (wrap), bout=1.
REQ-033 SHALL check that a=15, b=15 gives d=0, bout=0, and a=0, b=1 gives d=15, bout=1.
REQ-034 SHALL check that out_ready is held 0 for 3 cycles in DONE -> out_valid, d and in_ready=0 stay constant; with out_ready=1, IDLE follows the next cycle.
REQ-035 SHALL check that rst pulsed at the 2nd SHIFT cycle -> outputs 0, IDLE, no out_valid; then a=5, b=2 gives d=3.
REQ-036 SHALL check that in_valid held high back-to-back with a=8/b=1 then a=1/b=8 -> results 7 then 9, each accepted only in IDLE.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared constants and FSM state type for the bit-serial subtractor.
package sub_pkg;
  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/fs1bit.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
module fs1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub4.sv
// Bit-serial LSB-first 4-bit subtractor with valid/ready handshakes.
// Optional borrow-out port enabled by defining SUB_BORROW_OUT_EN.
module serial_sub4
  import sub_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a__0,
  input  logic a__1,
  input  logic a__2,
  input  logic a__3,
  input  logic b__0,
  input  logic b__1,
  input  logic b__2,
  input  logic b__3,
  input  logic in_valid,
  output logic in_ready,
  output logic d__0,
  output logic d__1,
  output logic d__2,
  output logic d__3,
  output logic out_valid,
`ifdef SUB_BORROW_OUT_EN
  output logic bout,
`endif
  input  logic out_ready
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               br_q;
  logic [WIDTH-1:0]   a_q, b_q, d_q;
  logic               out_valid_q;
  logic               fs_d, fs_bout;
  logic [WIDTH-1:0]   a_w, b_w;

  assign a_w = {a__3, a__2, a__1, a__0};
  assign b_w = {b__3, b__2, b__1, b__0};

  fs1bit u_fs (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

`ifdef SUB_BORROW_OUT_EN
  logic bout_q;
  assign bout = bout_q;

  // Final borrow captured on the same edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bout_q <= 1'b0;
    end else if (state_q == SHIFT && cnt_q == CNT_W'(WIDTH-1)) begin
      bout_q <= fs_bout;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a_w;
            b_q     <= b_w;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          d_q[cnt_q] <= fs_d;
          br_q       <= fs_bout;
          cnt_q      <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign d__0 = d_q[0];
  assign d__1 = d_q[1];
  assign d__2 = d_q[2];
  assign d__3 = d_q[3];

endmodule
